// File: rtl/deint_measurement_engine_if.sv
// Command, live-status and result handshake bundle for the deintegration measurement engine.
// The engine connects through the slave modport; the driving side uses master.
interface deint_measurement_engine_if #(
  parameter int WIDTH = 12
);
  logic             start_i;
  logic             abort_i;
  logic             pulse_en_i;
  logic             stop_i;
  logic             result_ready_i;
  logic [WIDTH-1:0] count_o;
  logic             busy_o;
  logic [WIDTH-1:0] result_data_o;
  logic             result_overflow_o;
  logic             result_valid_o;

  modport slave (
    input  start_i, abort_i, pulse_en_i, stop_i, result_ready_i,
    output count_o, busy_o, result_data_o, result_overflow_o, result_valid_o
  );

  modport master (
    output start_i, abort_i, pulse_en_i, stop_i, result_ready_i,
    input  count_o, busy_o, result_data_o, result_overflow_o, result_valid_o
  );
endinterface

// File: rtl/deint_measurement_engine.sv
// Deintegration pulse counter: counts pulses between start and comparator stop,
// applies offset calibration and timeout detection, and holds one result for a valid/ready readout.
module deint_measurement_engine #(
  parameter int WIDTH      = 12,
  parameter int MAX_COUNT  = (1 << WIDTH) - 1,
  parameter int CAL_OFFSET = 0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  deint_measurement_engine_if.slave     bus
);

  typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_e;

  localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MAX_COUNT);
  localparam logic [WIDTH:0] CAL_EXT = (WIDTH+1)'(CAL_OFFSET);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             ovf_q, ovf_d;

  // One bit of headroom so count+pulse and the offset subtraction can never wrap.
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   final_cnt;
  logic [WIDTH-1:0] calibrated;

  always_comb begin
    sum        = {1'b0, count_q} + {{WIDTH{1'b0}}, bus.pulse_en_i};
    final_cnt  = (sum > MAX_EXT) ? MAX_EXT : sum;
    calibrated = (final_cnt > CAL_EXT) ? WIDTH'(final_cnt - CAL_EXT) : '0;

    // NOTE: every next-state signal gets a default first so no path infers a latch.
    state_d = state_q;
    count_d = count_q;
    data_d  = data_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          state_d = COUNT;
          count_d = '0;
        end
      end
      COUNT: begin
        if (bus.abort_i) begin
          state_d = IDLE;
          count_d = '0;
        end else if (bus.stop_i) begin
          state_d = HOLD;
          count_d = final_cnt[WIDTH-1:0];
          data_d  = calibrated;
          ovf_d   = 1'b0;
        end else if (bus.pulse_en_i && ({1'b0, count_q} == MAX_EXT)) begin
          // Timeout: report the raw limit, never offset-corrected.
          state_d = HOLD;
          data_d  = MAX_EXT[WIDTH-1:0];
          ovf_d   = 1'b1;
        end else if (bus.pulse_en_i) begin
          count_d = sum[WIDTH-1:0];
        end
      end
      HOLD: begin
        if (bus.abort_i) begin
          state_d = IDLE;
          count_d = '0;
        end else if (bus.result_ready_i && bus.start_i) begin
          state_d = COUNT;
          count_d = '0;
        end else if (bus.result_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      count_q <= '0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.count_o           = count_q;
  assign bus.busy_o            = (state_q == COUNT);
  assign bus.result_data_o     = data_q;
  assign bus.result_overflow_o = ovf_q;
  assign bus.result_valid_o    = (state_q == HOLD);

endmodule

// File: tb/tb_deint_measurement_engine.sv
// Drives three engine configurations (12-bit, 12-bit with offset 5, 4-bit) with shared stimulus
// and checks them against directed expectations and a behavioural conversion model.
module tb_deint_measurement_engine;

  logic clk;
  logic rst;
  logic start, abort, pulse, stop, ready;
  int   checks;
  int   errors;

  deint_measurement_engine_if #(.WIDTH(12)) bus0 ();
  deint_measurement_engine_if #(.WIDTH(12)) bus1 ();
  deint_measurement_engine_if #(.WIDTH(4))  bus2 ();

  assign bus0.start_i = start;  assign bus0.abort_i = abort;  assign bus0.pulse_en_i = pulse;
  assign bus0.stop_i  = stop;   assign bus0.result_ready_i = ready;
  assign bus1.start_i = start;  assign bus1.abort_i = abort;  assign bus1.pulse_en_i = pulse;
  assign bus1.stop_i  = stop;   assign bus1.result_ready_i = ready;
  assign bus2.start_i = start;  assign bus2.abort_i = abort;  assign bus2.pulse_en_i = pulse;
  assign bus2.stop_i  = stop;   assign bus2.result_ready_i = ready;

  deint_measurement_engine #(.WIDTH(12), .CAL_OFFSET(0)) dut0 (.clk_i(clk), .rst_i(rst), .bus(bus0));
  deint_measurement_engine #(.WIDTH(12), .CAL_OFFSET(5)) dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1));
  deint_measurement_engine #(.WIDTH(4),  .CAL_OFFSET(0)) dut2 (.clk_i(clk), .rst_i(rst), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs gathered per configuration so the random test can loop over them.
  int   obs_count[3];
  int   obs_data[3];
  logic obs_busy[3];
  logic obs_valid[3];
  logic obs_ovf[3];
  always_comb begin
    obs_count[0] = int'(bus0.count_o); obs_data[0] = int'(bus0.result_data_o);
    obs_count[1] = int'(bus1.count_o); obs_data[1] = int'(bus1.result_data_o);
    obs_count[2] = int'(bus2.count_o); obs_data[2] = int'(bus2.result_data_o);
    obs_busy[0]  = bus0.busy_o;  obs_valid[0] = bus0.result_valid_o; obs_ovf[0] = bus0.result_overflow_o;
    obs_busy[1]  = bus1.busy_o;  obs_valid[1] = bus1.result_valid_o; obs_ovf[1] = bus1.result_overflow_o;
    obs_busy[2]  = bus2.busy_o;  obs_valid[2] = bus2.result_valid_o; obs_ovf[2] = bus2.result_overflow_o;
  end

  // Behavioural model: phase 0 = waiting, 1 = measuring, 2 = result pending.
  localparam int LIMIT[3]  = '{4095, 4095, 15};
  localparam int OFFSET[3] = '{0, 5, 0};
  int m_phase[3];
  int m_count[3];
  int m_data[3];
  int m_ovf[3];

  function automatic int reading(int cnt, int p, int lim, int off);
    int total;
    total = (cnt + p > lim) ? lim : cnt + p;
    return (total > off) ? total - off : 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        m_phase[i] <= 0; m_count[i] <= 0; m_data[i] <= 0; m_ovf[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (m_phase[i] == 0) begin
          if (start) begin m_phase[i] <= 1; m_count[i] <= 0; end
        end else if (m_phase[i] == 1) begin
          if (abort) begin
            m_phase[i] <= 0; m_count[i] <= 0;
          end else if (stop) begin
            m_phase[i] <= 2;
            m_count[i] <= reading(m_count[i], int'(pulse), LIMIT[i], 0);
            m_data[i]  <= reading(m_count[i], int'(pulse), LIMIT[i], OFFSET[i]);
            m_ovf[i]   <= 0;
          end else if (pulse && m_count[i] == LIMIT[i]) begin
            m_phase[i] <= 2; m_data[i] <= LIMIT[i]; m_ovf[i] <= 1;
          end else if (pulse) begin
            m_count[i] <= m_count[i] + 1;
          end
        end else begin
          if (abort) begin
            m_phase[i] <= 0; m_count[i] <= 0;
          end else if (ready) begin
            m_phase[i] <= start ? 1 : 0;
            if (start) m_count[i] <= 0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; abort = 0; pulse = 0; stop = 0; ready = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({bus0.count_o, bus0.result_data_o, bus0.busy_o, bus0.result_valid_o, bus0.result_overflow_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got cnt=%0d data=%0d busy=%b valid=%b ovf=%b required all zero",
               bus0.count_o, bus0.result_data_o, bus0.busy_o, bus0.result_valid_o, bus0.result_overflow_o);
    end
  endtask

  task automatic test_basic();
    apply_reset();
    start = 1; tick(); start = 0;
    checks++; if (bus0.busy_o !== 1'b1) begin errors++; $display("FAIL basic_busy got %b required 1", bus0.busy_o); end
    pulse = 1; repeat (100) tick(); pulse = 0;
    stop = 1; tick(); stop = 0;
    checks++; if (bus0.result_valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid got %b required 1", bus0.result_valid_o); end
    checks++; if (bus0.result_data_o !== 12'd100) begin errors++; $display("FAIL basic_data got %0d required 100", bus0.result_data_o); end
    checks++; if (bus0.result_overflow_o !== 1'b0) begin errors++; $display("FAIL basic_ovf got %b required 0", bus0.result_overflow_o); end
    ready = 1; tick(); ready = 0;
    checks++; if ({bus0.result_valid_o, bus0.busy_o} !== 2'b00) begin errors++; $display("FAIL basic_release got valid/busy %b required 00", {bus0.result_valid_o, bus0.busy_o}); end
  endtask

  task automatic test_offset();
    apply_reset();
    start = 1; tick(); start = 0;
    pulse = 1; repeat (3) tick(); pulse = 0;
    stop = 1; tick(); stop = 0;
    checks++; if (bus1.result_data_o !== 12'd0 || bus1.result_valid_o !== 1'b1) begin errors++; $display("FAIL offset_clamp got data=%0d valid=%b required 0/1", bus1.result_data_o, bus1.result_valid_o); end
    ready = 1; tick(); ready = 0;
    start = 1; tick(); start = 0;
    pulse = 1; repeat (20) tick(); pulse = 0;
    stop = 1; tick(); stop = 0;
    checks++; if (bus1.result_data_o !== 12'd15) begin errors++; $display("FAIL offset_sub got %0d required 15", bus1.result_data_o); end
    ready = 1; tick(); ready = 0;
  endtask

  task automatic test_overflow();
    apply_reset();
    start = 1; tick(); start = 0;
    pulse = 1; repeat (15) tick();
    checks++; if (bus2.count_o !== 4'd15 || bus2.result_valid_o !== 1'b0) begin errors++; $display("FAIL ovf_pre got cnt=%0d valid=%b required 15/0", bus2.count_o, bus2.result_valid_o); end
    tick();
    checks++;
    if ({bus2.result_valid_o, bus2.result_overflow_o, bus2.result_data_o, bus2.count_o} !== {1'b1, 1'b1, 4'd15, 4'd15}) begin
      errors++; $display("FAIL ovf_hit got valid=%b ovf=%b data=%0d cnt=%0d required 1/1/15/15",
                         bus2.result_valid_o, bus2.result_overflow_o, bus2.result_data_o, bus2.count_o);
    end
    repeat (5) tick();
    checks++;
    if ({bus2.result_valid_o, bus2.result_overflow_o, bus2.result_data_o, bus2.count_o} !== {1'b1, 1'b1, 4'd15, 4'd15}) begin
      errors++; $display("FAIL ovf_hold got valid=%b ovf=%b data=%0d cnt=%0d required 1/1/15/15",
                         bus2.result_valid_o, bus2.result_overflow_o, bus2.result_data_o, bus2.count_o);
    end
    pulse = 0; ready = 1; tick(); ready = 0;
  endtask

  task automatic test_stop_abort();
    apply_reset();
    start = 1; tick(); start = 0;
    pulse = 1; repeat (41) tick();
    stop = 1; tick(); stop = 0; pulse = 0;
    checks++; if (bus0.result_data_o !== 12'd42) begin errors++; $display("FAIL stop_with_pulse got %0d required 42", bus0.result_data_o); end
    ready = 1; tick(); ready = 0;
    start = 1; tick(); start = 0;
    pulse = 1; repeat (9) tick(); pulse = 0;
    abort = 1; stop = 1; tick(); abort = 0; stop = 0;
    checks++;
    if ({bus0.result_valid_o, bus0.busy_o, bus0.count_o} !== {1'b0, 1'b0, 12'd0}) begin
      errors++; $display("FAIL abort_stop got valid=%b busy=%b cnt=%0d required 0/0/0", bus0.result_valid_o, bus0.busy_o, bus0.count_o);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    start = 1; tick(); start = 0;
    pulse = 1; repeat (7) tick(); pulse = 0;
    stop = 1; tick(); stop = 0;
    for (int i = 0; i < 10; i++) begin
      start = i[0]; pulse = 1;
      tick();
      checks++;
      if (bus0.result_data_o !== 12'd7 || bus0.result_valid_o !== 1'b1) begin
        errors++; $display("FAIL hold_stable cycle %0d got data=%0d valid=%b required 7/1", i, bus0.result_data_o, bus0.result_valid_o);
      end
    end
    pulse = 0; start = 1; ready = 1; tick(); start = 0; ready = 0;
    checks++;
    if ({bus0.result_valid_o, bus0.busy_o, bus0.count_o} !== {1'b0, 1'b1, 12'd0}) begin
      errors++; $display("FAIL back_to_back got valid=%b busy=%b cnt=%0d required 0/1/0", bus0.result_valid_o, bus0.busy_o, bus0.count_o);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    start = 1; tick(); start = 0;
    pulse = 1; repeat (50) tick(); pulse = 0;
    checks++; if (bus0.count_o !== 12'd50) begin errors++; $display("FAIL arst_precount got %0d required 50", bus0.count_o); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus0.count_o, bus0.busy_o, bus0.result_valid_o, bus0.result_data_o, bus0.result_overflow_o} !== '0) begin
      errors++; $display("FAIL arst_count got cnt=%0d busy=%b required all zero", bus0.count_o, bus0.busy_o);
    end
    #3 rst = 1'b0;
    stop = 1; pulse = 1; abort = 1; ready = 1;
    repeat (3) tick();
    idle_inputs();
    checks++;
    if ({bus0.count_o, bus0.busy_o, bus0.result_valid_o} !== '0) begin
      errors++; $display("FAIL idle_ignore got cnt=%0d busy=%b valid=%b required 0/0/0", bus0.count_o, bus0.busy_o, bus0.result_valid_o);
    end
    start = 1; tick(); start = 0;
    pulse = 1; repeat (3) tick(); pulse = 0;
    stop = 1; tick(); stop = 0;
    checks++; if (bus0.result_valid_o !== 1'b1) begin errors++; $display("FAIL arst_prehold got valid=%b required 1", bus0.result_valid_o); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus0.count_o, bus0.busy_o, bus0.result_valid_o, bus0.result_data_o, bus0.result_overflow_o} !== '0) begin
      errors++; $display("FAIL arst_hold got cnt=%0d data=%0d valid=%b required all zero", bus0.count_o, bus0.result_data_o, bus0.result_valid_o);
    end
    #3 rst = 1'b0;
    tick();
  endtask

  task automatic test_random();
    apply_reset();
    for (int n = 0; n < 3000; n++) begin
      start = ($urandom_range(0, 7) == 0);
      abort = ($urandom_range(0, 40) == 0);
      stop  = ($urandom_range(0, 24) == 0);
      pulse = ($urandom_range(0, 3) != 0);
      ready = ($urandom_range(0, 2) == 0);
      tick();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_valid[i] !== (m_phase[i] == 2) || obs_busy[i] !== (m_phase[i] == 1) || obs_count[i] != m_count[i]) begin
          errors++;
          $display("FAIL rand_state cfg%0d cyc %0d got valid=%b busy=%b cnt=%0d required valid=%b busy=%b cnt=%0d",
                   i, n, obs_valid[i], obs_busy[i], obs_count[i], m_phase[i] == 2, m_phase[i] == 1, m_count[i]);
        end
        if (m_phase[i] == 2) begin
          checks++;
          if (obs_data[i] != m_data[i] || obs_ovf[i] !== m_ovf[i][0]) begin
            errors++;
            $display("FAIL rand_result cfg%0d cyc %0d got data=%0d ovf=%b required data=%0d ovf=%0d",
                     i, n, obs_data[i], obs_ovf[i], m_data[i], m_ovf[i]);
          end
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_basic();
    test_offset();
    test_overflow();
    test_stop_abort();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
